// File: rtl/wb_ser_pkg.sv
// Shared types and default widths for the writeback result serializer.
package wb_ser_pkg;
    localparam int unsigned DEF_DATA_WIDTH = 16;
    localparam int unsigned DEF_OUT_WIDTH  = 8;
    localparam int unsigned DEF_FIFO_DEPTH = 4;
    localparam int unsigned PTR_W          = $clog2(DEF_FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND_LO = 2'd1,
        SEND_HI = 2'd2
    } ser_state_e;
endpackage

// File: rtl/wb_result_serializer_if.sv
// Capture and byte-stream handshake bundle for wb_result_serializer.
interface wb_result_serializer_if
    import wb_ser_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned OUT_WIDTH  = DEF_OUT_WIDTH
);
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic [OUT_WIDTH-1:0]  out_byte;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  out_byte, out_valid, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output out_byte, out_valid, out_last
    );
endinterface

// File: rtl/wb_word_fifo.sv
// Synchronous word FIFO; push and pop may coincide even when full.
module wb_word_fifo
    import wb_ser_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned DEPTH = DEF_FIFO_DEPTH,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned LW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    level_next;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_comb begin
        level_next = level;
        case ({do_push, do_pop})
            2'b10:   level_next = level + LW'(1);
            2'b01:   level_next = level - LW'(1);
            default: level_next = level;
        endcase
    end

    // Flags are registered from the next level so they never lag the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            level <= level_next;
            full  <= (level_next == LW'(DEPTH));
            empty <= (level_next == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/wb_result_serializer.sv
// Captures writeback words into a FIFO and streams them out low byte first.
// Optional WB_SER_CHANGE_FILTER_EN: only push words that differ from the last accepted one.
module wb_result_serializer
    import wb_ser_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned OUT_WIDTH  = DEF_OUT_WIDTH,
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
    localparam int unsigned LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    wb_result_serializer_if.slave  bus,
    output logic                   fifo_full,
    output logic                   overflow,
    output logic [LVL_W-1:0]       level
);
    ser_state_e            state;
    ser_state_e            state_next;
    logic [DATA_WIDTH-1:0] hold;
    logic [DATA_WIDTH-1:0] hold_next;
    logic [DATA_WIDTH-1:0] fifo_head;
    logic                  fifo_empty;
    logic                  pop;
    logic                  push_cand;
    logic                  push;
    logic [OUT_WIDTH-1:0]  byte_next;
    logic                  valid_next;
    logic                  last_next;

`ifdef WB_SER_CHANGE_FILTER_EN
    logic [DATA_WIDTH-1:0] last_word;
    logic                  last_vld;

    assign push_cand = bus.in_valid && (!last_vld || (bus.in_data != last_word));

    // Dropped words never reach here, so they do not become the compare value.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_vld  <= 1'b0;
            last_word <= '0;
        end else if (push) begin
            last_vld  <= 1'b1;
            last_word <= bus.in_data;
        end
    end
`else
    assign push_cand = bus.in_valid;
`endif

    assign push = push_cand && (!fifo_full || pop);

    wb_word_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (bus.in_data),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (level)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (push_cand && fifo_full && !pop) begin
            overflow <= 1'b1;
        end
    end

    // State, hold word and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            hold          <= '0;
            bus.out_valid <= 1'b0;
            bus.out_byte  <= '0;
            bus.out_last  <= 1'b0;
        end else begin
            state         <= state_next;
            hold          <= hold_next;
            bus.out_valid <= valid_next;
            bus.out_byte  <= byte_next;
            bus.out_last  <= last_next;
        end
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = SEND_LO;
                end
            end
            SEND_LO: begin
                if (bus.out_ready) state_next = SEND_HI;
            end
            SEND_HI: begin
                if (bus.out_ready) begin
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        state_next = SEND_LO;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs decode the next state so they appear registered with it.
    always_comb begin
        hold_next  = pop ? fifo_head : hold;
        valid_next = 1'b0;
        byte_next  = '0;
        last_next  = 1'b0;
        case (state_next)
            SEND_LO: begin
                valid_next = 1'b1;
                byte_next  = hold_next[OUT_WIDTH-1:0];
            end
            SEND_HI: begin
                valid_next = 1'b1;
                byte_next  = hold_next[DATA_WIDTH-1 -: OUT_WIDTH];
                last_next  = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_wb_result_serializer.sv
// Directed self-checking bench for wb_result_serializer.
module tb_wb_result_serializer;
    import wb_ser_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       fifo_full;
    logic       overflow;
    logic [2:0] level;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [7:0] bq[$];
    logic       lq[$];
    int         cq[$];

    always #5 clk = ~clk;

    wb_result_serializer_if bus ();

    wb_result_serializer dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .fifo_full (fifo_full),
        .overflow  (overflow),
        .level     (level)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Record every byte that will be accepted at the coming rising edge.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            bq.push_back(bus.out_byte);
            lq.push_back(bus.out_last);
            cq.push_back(cyc);
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_word(input logic [15:0] d);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic clear_q();
        bq.delete();
        lq.delete();
        cq.delete();
    endtask

    task automatic wait_bytes(input int n, input int budget);
        int k = 0;
        while (bq.size() < n && k < budget) begin
            tick();
            k++;
        end
    endtask

    task automatic check_stream(input string tag, input logic [7:0] exp_b[$]);
        check_val({tag, "_count"}, 32'(bq.size()), 32'(exp_b.size()));
        for (int i = 0; i < exp_b.size() && i < bq.size(); i++) begin
            check_val($sformatf("%s_byte%0d", tag, i), 32'(bq[i]), 32'(exp_b[i]));
            check_val($sformatf("%s_last%0d", tag, i), 32'(lq[i]), 32'(i % 2));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] exp_b[$];
        int         k;

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        tick(2);
        rst = 1'b0;

        check_val("rst_valid", 32'(bus.out_valid), 0);
        check_val("rst_byte", 32'(bus.out_byte), 0);
        check_val("rst_last", 32'(bus.out_last), 0);
        check_val("rst_level", 32'(level), 0);
        check_val("rst_full", 32'(fifo_full), 0);
        check_val("rst_ovf", 32'(overflow), 0);

        // Single word latency and byte order
        clear_q();
        bus.out_ready = 1'b1;
        push_word(16'h1234);
        check_val("t1_lvl_n1", 32'(level), 1);
        check_val("t1_valid_n1", 32'(bus.out_valid), 0);
        tick();
        check_val("t1_valid_n2", 32'(bus.out_valid), 1);
        check_val("t1_lo", 32'(bus.out_byte), 32'h34);
        check_val("t1_lo_last", 32'(bus.out_last), 0);
        tick();
        check_val("t1_hi", 32'(bus.out_byte), 32'h12);
        check_val("t1_hi_last", 32'(bus.out_last), 1);
        tick();
        check_val("t1_idle", 32'(bus.out_valid), 0);

        // Back-to-back words, no bubbles
        clear_q();
        push_word(16'hAAAA);
        push_word(16'hBBBB);
        push_word(16'hCCCC);
        wait_bytes(6, 20);
        exp_b = '{8'hAA, 8'hAA, 8'hBB, 8'hBB, 8'hCC, 8'hCC};
        check_stream("t2", exp_b);
        for (int i = 1; i < 6 && i < cq.size(); i++)
            check_val($sformatf("t2_gap%0d", i), 32'(cq[i] - cq[i-1]), 1);
        tick(3);

        // Fill to full and overflow while the consumer stalls
        clear_q();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 6; i++) push_word(16'h1001 + 16'(i));
        check_val("t3_level", 32'(level), 4);
        check_val("t3_full", 32'(fifo_full), 1);
        check_val("t3_ovf", 32'(overflow), 1);
        check_val("t3_head_lo", 32'(bus.out_byte), 32'h01);
        bus.out_ready = 1'b1;
        wait_bytes(10, 40);
        tick(4);
        exp_b.delete();
        for (int i = 0; i < 5; i++) begin
            exp_b.push_back(8'(i + 1));
            exp_b.push_back(8'h10);
        end
        check_stream("t3", exp_b);
        check_val("t3_ovf_sticky", 32'(overflow), 1);

        // Stall in SEND_HI keeps the byte stable
        clear_q();
        bus.out_ready = 1'b0;
        push_word(16'h2211);
        push_word(16'h4433);
        k = 0;
        while (!bus.out_valid && k < 10) begin
            tick();
            k++;
        end
        check_val("t4_lo", 32'(bus.out_byte), 32'h11);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_val($sformatf("t4_hold_byte%0d", i), 32'(bus.out_byte), 32'h22);
            check_val($sformatf("t4_hold_last%0d", i), 32'(bus.out_last), 1);
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        check_val("t4_next_lo", 32'(bus.out_byte), 32'h33);
        check_val("t4_next_last", 32'(bus.out_last), 0);
        wait_bytes(4, 10);
        tick(3);

        // Reset in the middle of a word
        bus.out_ready = 1'b0;
        for (int i = 0; i < 6; i++) push_word(16'h5001 + 16'(i));
        check_val("t5_ovf_pre", 32'(overflow), 1);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check_val("t5_in_hi", 32'(bus.out_last), 1);
        rst = 1'b1;
        tick();
        check_val("t5_valid", 32'(bus.out_valid), 0);
        check_val("t5_level", 32'(level), 0);
        check_val("t5_ovf", 32'(overflow), 0);
        check_val("t5_full", 32'(fifo_full), 0);
        rst = 1'b0;
        clear_q();
        bus.out_ready = 1'b1;
        push_word(16'h7788);
        wait_bytes(2, 10);
        tick(3);
        exp_b = '{8'h88, 8'h77};
        check_stream("t5", exp_b);

        // Repeated words with and without the change filter
        clear_q();
        push_word(16'h0005);
        push_word(16'h0005);
        push_word(16'h0005);
        push_word(16'h0006);
`ifdef WB_SER_CHANGE_FILTER_EN
        exp_b = '{8'h05, 8'h00, 8'h06, 8'h00};
`else
        exp_b = '{8'h05, 8'h00, 8'h05, 8'h00, 8'h05, 8'h00, 8'h06, 8'h00};
`endif
        wait_bytes(exp_b.size(), 30);
        tick(6);
        check_stream("t6", exp_b);
        check_val("t6_ovf", 32'(overflow), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
